// File: rtl/event_framer.sv
// Frames per-event drift-tube words as header / body / trailer into the readout FIFO.
// Define ZERO_SUPPRESS_EN to discard body words whose drift-time byte is zero.
module event_framer #(
  parameter int unsigned EVT_ID_W  = 12,
  parameter int unsigned BUF_DEPTH = 8,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                clk100,
  input  logic                rst,
  input  logic [15:0]         in_data,
  input  logic                in_valid,
  input  logic                in_last,
  output logic [15:0]         fifo_din,
  output logic                fifo_wr_en,
  input  logic                fifo_full,
  output logic [EVT_ID_W-1:0] evt_count,
  output logic [CNT_W-1:0]    drop_count,
  output logic                busy
);

  localparam int unsigned PtrW = $clog2(BUF_DEPTH);
  localparam logic [PtrW:0] DepthCnt = (PtrW + 1)'(BUF_DEPTH);

  typedef enum logic [1:0] {StIdle, StHdr, StBody, StTrl} state_e;

  // Elastic buffer: each entry is {last, word}
  logic [16:0]      buf_mem [BUF_DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]    count_q, count_d;
  logic             buf_empty, buf_full;
  logic [16:0]      head;

  state_e           state_q, state_d;
  logic [EVT_ID_W-1:0] evt_id_q, evt_id_d;
  logic [5:0]       hits_q, hits_d;
  logic             ovf_q, ovf_d;
  logic             pend_close_q, pend_close_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic [15:0]      out_q, out_d;
  logic             out_vld_q, out_vld_d;

  logic             push, pop, drop;
  logic             suppress;
  logic             out_load, hit_inc, frame_done;
  logic [15:0]      out_word;
  logic [11:0]      evt_id_ext;

  assign buf_empty  = (count_q == '0);
  assign buf_full   = (count_q == DepthCnt);
  assign head       = buf_mem[rd_ptr_q];
  assign evt_id_ext = 12'(evt_id_q);

`ifdef ZERO_SUPPRESS_EN
  assign suppress = (head[15:8] == 8'h00);
`else
  assign suppress = 1'b0;
`endif

  // A pop in the same cycle frees a slot before the push lands
  assign push = in_valid && (!buf_full || pop);
  assign drop = in_valid && buf_full && !pop;

  // Drain FSM: every transition waits for a non-full FIFO
  always_comb begin
    state_d    = state_q;
    pop        = 1'b0;
    out_load   = 1'b0;
    out_word   = '0;
    hit_inc    = 1'b0;
    frame_done = 1'b0;
    if (!fifo_full) begin
      unique case (state_q)
        StIdle: begin
          if (!buf_empty || pend_close_q) state_d = StHdr;
        end
        StHdr: begin
          out_load = 1'b1;
          out_word = {4'hA, evt_id_ext};
          state_d  = StBody;
        end
        StBody: begin
          if (!buf_empty) begin
            pop = 1'b1;
            if (!suppress) begin
              out_load = 1'b1;
              out_word = head[15:0];
              hit_inc  = 1'b1;
            end
            if (head[16]) state_d = StTrl;
          end else if (pend_close_q) begin
            state_d = StTrl;
          end
        end
        StTrl: begin
          out_load   = 1'b1;
          out_word   = {4'hC, ovf_q, 5'b0, hits_q};
          frame_done = 1'b1;
          state_d    = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Buffer pointers and occupancy
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    unique case ({push, pop})
      2'b10:   count_d = count_q + (PtrW + 1)'(1);
      2'b01:   count_d = count_q - (PtrW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Per-frame bookkeeping; a new drop on the trailer cycle belongs to the next frame
  always_comb begin
    evt_id_d     = evt_id_q;
    hits_d       = hits_q;
    ovf_d        = ovf_q;
    pend_close_d = pend_close_q;
    drop_d       = drop_q;
    if (frame_done) begin
      evt_id_d     = evt_id_q + EVT_ID_W'(1);
      hits_d       = '0;
      ovf_d        = 1'b0;
      pend_close_d = 1'b0;
    end else if (hit_inc) begin
      hits_d = hits_q + 6'd1;
    end
    if (drop) begin
      ovf_d = 1'b1;
      if (in_last) pend_close_d = 1'b1;
      if (drop_q != '1) drop_d = drop_q + CNT_W'(1);
    end
  end

  // Output word register; a word loaded just before the FIFO fills is held, not lost
  always_comb begin
    out_d     = out_q;
    out_vld_d = out_vld_q && fifo_full;
    if (out_load) begin
      out_d     = out_word;
      out_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk100) begin
    if (push) buf_mem[wr_ptr_q] <= {in_last, in_data};
  end

  always_ff @(posedge clk100) begin
    if (rst) begin
      state_q      <= StIdle;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      evt_id_q     <= '0;
      hits_q       <= '0;
      ovf_q        <= 1'b0;
      pend_close_q <= 1'b0;
      drop_q       <= '0;
      out_q        <= '0;
      out_vld_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      evt_id_q     <= evt_id_d;
      hits_q       <= hits_d;
      ovf_q        <= ovf_d;
      pend_close_q <= pend_close_d;
      drop_q       <= drop_d;
      out_q        <= out_d;
      out_vld_q    <= out_vld_d;
    end
  end

  assign fifo_din   = out_q;
  assign fifo_wr_en = out_vld_q && !fifo_full;
  assign evt_count  = evt_id_q;
  assign drop_count = drop_q;
  assign busy       = (state_q != StIdle) || !buf_empty;

endmodule

// File: tb/tb_event_framer.sv
// Directed bench for event_framer: frame table plus overflow, lost-last, reset and wrap sequences.
module tb_event_framer;

  localparam int unsigned EvtIdW   = 12;
  localparam int unsigned BufDepth = 8;
  localparam int unsigned CntW     = 16;
`ifdef ZERO_SUPPRESS_EN
  localparam bit Zs = 1'b1;
`else
  localparam bit Zs = 1'b0;
`endif

  logic              clk100 = 1'b0;
  logic              rst;
  logic [15:0]       in_data;
  logic              in_valid;
  logic              in_last;
  logic [15:0]       fifo_din;
  logic              fifo_wr_en;
  logic              fifo_full;
  logic [EvtIdW-1:0] evt_count;
  logic [CntW-1:0]   drop_count;
  logic              busy;

  always #5 clk100 = ~clk100;

  event_framer #(
    .EVT_ID_W (EvtIdW),
    .BUF_DEPTH(BufDepth),
    .CNT_W    (CntW)
  ) dut (
    .clk100    (clk100),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .fifo_din  (fifo_din),
    .fifo_wr_en(fifo_wr_en),
    .fifo_full (fifo_full),
    .evt_count (evt_count),
    .drop_count(drop_count),
    .busy      (busy)
  );

  int checks = 0;
  int errors = 0;
  logic [15:0] got[$];
  logic [15:0] exp_q[$];

  typedef struct {
    int unsigned n;
    logic [15:0] base;
    logic [15:0] trl;
  } frame_t;
  frame_t tbl [4];

  // FIFO model: capture writes mid-cycle; a write while full would be lost
  always @(negedge clk100) begin
    if (fifo_wr_en) got.push_back(fifo_din);
    if (fifo_full) begin
      checks++;
      if (fifo_wr_en) begin
        errors++;
        $display("FAIL wr_while_full: fifo_wr_en=%b while fifo_full=1, required 0", fifo_wr_en);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [15:0] d, input logic l, input logic f);
    @(posedge clk100);
    #1;
    in_valid  = v;
    in_data   = d;
    in_last   = l;
    fifo_full = f;
  endtask

  task automatic do_reset();
    @(posedge clk100);
    #1;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_data   = '0;
    fifo_full = 1'b0;
    @(posedge clk100);
    #1;
    rst = 1'b0;
    got.delete();
    exp_q.delete();
  endtask

  task automatic drain(input int budget);
    int n = 0;
    drive(1'b0, 16'h0000, 1'b0, 1'b0);
    while ((busy || fifo_wr_en) && n < budget) begin
      @(posedge clk100);
      #1;
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL drain_timeout: still busy after %0d cycles, required idle", n);
    end
    @(posedge clk100);
    #1;
  endtask

  task automatic check_frames(input string name);
    check({name, " len"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      check($sformatf("%s[%0d]", name, i), got[i], exp_q[i]);
    got.delete();
    exp_q.delete();
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_data   = '0;
    fifo_full = 1'b0;

    tbl[0] = '{32, 16'h0500, 16'hC020};
    tbl[1] = '{1,  16'h1234, 16'hC001};
    tbl[2] = '{5,  16'h00FB, Zs ? 16'hC000 : 16'hC005};
    tbl[3] = '{3,  16'h00FF, Zs ? 16'hC002 : 16'hC003};

    do_reset();
    check("rst wr_en", fifo_wr_en, 0);
    check("rst din", fifo_din, 0);
    check("rst evt_count", evt_count, 0);
    check("rst drop_count", drop_count, 0);
    check("rst busy", busy, 0);

    // Frame table, with idle gaps so the buffer never overflows
    for (int f = 0; f < 4; f++) begin
      exp_q.push_back(16'hA000 + 16'(f));
      for (int i = 0; i < int'(tbl[f].n); i++) begin
        logic [15:0] w;
        w = tbl[f].base + 16'(i);
        drive(1'b1, w, i == int'(tbl[f].n) - 1, 1'b0);
        if (!Zs || w[15:8] != 8'h00) exp_q.push_back(w);
      end
      exp_q.push_back(tbl[f].trl);
      repeat (6) drive(1'b0, 16'h0000, 1'b0, 1'b0);
    end
    drain(200);
    check_frames("table");
    check("table evt_count", evt_count, 4);
    check("table drop_count", drop_count, 0);
    check("table busy", busy, 0);

    // Mostly unfired tubes; only three carry a drift time
    exp_q.push_back(16'hA004);
    for (int i = 0; i < 32; i++) begin
      logic [15:0] w;
      w = (i == 3 || i == 10 || i == 30) ? {8'h40, 8'(i)} : {8'h00, 8'(i)};
      drive(1'b1, w, i == 31, 1'b0);
      if (!Zs || w[15:8] != 8'h00) exp_q.push_back(w);
    end
    exp_q.push_back(Zs ? 16'hC003 : 16'hC020);
    drain(200);
    check_frames("zs");
    check("zs evt_count", evt_count, 5);

    // FIFO full for 20 cycles from word 5: 8 buffered, 15 dropped, 17 written
    do_reset();
    for (int i = 0; i < 32; i++)
      drive(1'b1, 16'h0500 + 16'(i), i == 31, i >= 5 && i < 25);
    drain(200);
    exp_q.push_back(16'hA000);
    for (int i = 0; i < 10; i++) exp_q.push_back(16'h0500 + 16'(i));
    for (int i = 25; i < 32; i++) exp_q.push_back(16'h0500 + 16'(i));
    exp_q.push_back(16'hC811);
    check_frames("ovf");
    check("ovf drop_count", drop_count, 15);
    check("ovf evt_count", evt_count, 1);

    // Last word lost to a full buffer: frame still closes, flagged
    for (int i = 0; i < 12; i++)
      drive(1'b1, 16'h0600 + 16'(i), i == 11, 1'b1);
    repeat (3) drive(1'b0, 16'h0000, 1'b0, 1'b1);
    check("lost drop_count", drop_count, 19);
    check("lost held", got.size(), 0);
    drain(200);
    exp_q.push_back(16'hA001);
    for (int i = 0; i < 8; i++) exp_q.push_back(16'h0600 + 16'(i));
    exp_q.push_back(16'hC808);
    check_frames("lost");
    drive(1'b1, 16'h0700, 1'b0, 1'b0);
    drive(1'b1, 16'h0701, 1'b1, 1'b0);
    drain(200);
    exp_q.push_back(16'hA002);
    exp_q.push_back(16'h0700);
    exp_q.push_back(16'h0701);
    exp_q.push_back(16'hC002);
    check_frames("after_lost");
    check("after_lost evt_count", evt_count, 3);

    // Reset part-way through a body; the in_valid word at the reset edge is ignored
    for (int i = 0; i < 32; i++) begin
      drive(1'b1, 16'h0800 + 16'(i), i == 31, 1'b0);
      if (i == 12) begin
        rst = 1'b1;
        break;
      end
    end
    check("pre_rst progress", got.size() > 4, 1);
    @(posedge clk100);
    #1;
    check("mid_rst wr_en", fifo_wr_en, 0);
    check("mid_rst din", fifo_din, 0);
    check("mid_rst evt_count", evt_count, 0);
    check("mid_rst drop_count", drop_count, 0);
    check("mid_rst busy", busy, 0);
    rst      = 1'b0;
    in_valid = 1'b0;
    got.delete();
    for (int i = 0; i < 3; i++) drive(1'b1, 16'h0900 + 16'(i), i == 2, 1'b0);
    drain(200);
    exp_q.push_back(16'hA000);
    for (int i = 0; i < 3; i++) exp_q.push_back(16'h0900 + 16'(i));
    exp_q.push_back(16'hC003);
    check_frames("post_rst");

    // Event-ID wrap over 4097 single-word events
    do_reset();
    for (int e = 0; e < 4097; e++) begin
      drive(1'b1, 16'h0101, 1'b1, 1'b0);
      repeat (4) drive(1'b0, 16'h0000, 1'b0, 1'b0);
    end
    drain(200);
    check("wrap len", got.size(), 4097 * 3);
    if (got.size() == 4097 * 3) begin
      check("wrap hdr4095", got[4095 * 3], 16'hAFFF);
      check("wrap hdr4096", got[4096 * 3], 16'hA000);
      check("wrap body4096", got[4096 * 3 + 1], 16'h0101);
      check("wrap trl4096", got[4096 * 3 + 2], 16'hC001);
    end
    check("wrap evt_count", evt_count, 1);
    check("wrap drop_count", drop_count, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
